multibit: RTL and testbench



---
 rtl/multibit.sv | 93 +++++++++
 tb/tb_multibit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multibit.sv
// multibit: registered N-bit barrel rotator/shifter; result one cycle after in_valid, no backpressure (accepts every cycle).
// Defining MULTIBIT_CARRY_OUT_EN adds a registered carry-out port CO holding the last bit moved across the word boundary.
module multibit #(
    parameter int N = 8,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] YY,
    input  logic [N-1:0] XX,
    input  logic         DIR,
    input  logic [M-1:0] AMT,
    input  logic [1:0]   MODE,
    input  logic         in_valid,
    output logic         out_valid
`ifdef MULTIBIT_CARRY_OUT_EN
    ,
    output logic         CO
`endif
);

    localparam logic [1:0] MODE_ROT = 2'b00;
    localparam logic [1:0] MODE_ASH = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    logic         is_rot;
    logic         fill_bit;
    logic [N-1:0] norm_in;
    logic [N-1:0] norm_out;
    logic [N-1:0] result;
    logic [N-1:0] stage_w [0:M];

    assign is_rot   = (MODE == MODE_ROT) || (MODE == MODE_RSV);
    assign fill_bit = (MODE == MODE_ASH) && DIR && XX[N-1];

    // Left operations are done as right operations on the bit-reversed word,
    // so only one right-acting shifter network is needed.
    assign norm_in    = DIR ? XX : bit_rev(XX);
    assign stage_w[0] = norm_in;

    for (genvar s = 0; s < M; s++) begin : g_stage
        localparam int K = 1 << s;
        logic [N-1:0] rot_w;
        logic [N-1:0] shf_w;

        assign rot_w          = {stage_w[s][K-1:0], stage_w[s][N-1:K]};
        assign shf_w          = {{K{fill_bit}}, stage_w[s][N-1:K]};
        assign stage_w[s+1]   = !AMT[s] ? stage_w[s] : (is_rot ? rot_w : shf_w);
    end

    assign norm_out = stage_w[M];
    assign result   = DIR ? norm_out : bit_rev(norm_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            YY        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                YY <= result;
            end
        end
    end

`ifdef MULTIBIT_CARRY_OUT_EN
    // In the normalised (right-acting) domain the last bit out is always bit AMT-1,
    // which maps back to XX[N-AMT] for left operations.
    logic [M-1:0] amt_m1;
    logic         carry_bit;

    assign amt_m1    = AMT - M'(1);
    assign carry_bit = (AMT != '0) && norm_in[amt_m1];

    always_ff @(posedge clk) begin
        if (rst) begin
            CO <= 1'b0;
        end else if (in_valid) begin
            CO <= carry_bit;
        end
    end
`endif

endmodule

// File: tb/tb_multibit.sv
// Randomised and directed self-checking bench for multibit against a per-bit reference model.
module tb_multibit;

    localparam int N = 8;
    localparam int M = 3;
    localparam logic [1:0] ROT = 2'b00;
    localparam logic [1:0] LSH = 2'b01;
    localparam logic [1:0] ASH = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] YY;
    logic [N-1:0] XX;
    logic         DIR;
    logic [M-1:0] AMT;
    logic [1:0]   MODE;
    logic         in_valid;
    logic         out_valid;
`ifdef MULTIBIT_CARRY_OUT_EN
    logic         CO;
`endif

    multibit #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .YY        (YY),
        .XX        (XX),
        .DIR       (DIR),
        .AMT       (AMT),
        .MODE      (MODE),
        .in_valid  (in_valid),
        .out_valid (out_valid)
`ifdef MULTIBIT_CARRY_OUT_EN
        ,
        .CO        (CO)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_yy;
    logic         m_ov;
    logic         m_co;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each output bit i takes the input bit A places away; positions falling off
    // the word wrap around (rotate) or take the fill value (shift).
    function automatic logic [N-1:0] ref_op(input logic [N-1:0] x, input logic dir,
                                            input int a, input logic [1:0] mode);
        logic [N-1:0] r;
        logic         fill;
        int           src;
        fill = (mode == ASH && dir) ? x[N-1] : 1'b0;
        r = '0;
        for (int i = 0; i < N; i++) begin
            src = dir ? i + a : i - a;
            if (src >= 0 && src < N)       r[i] = x[src];
            else if (mode == ROT || mode == RSV) r[i] = x[(src + N) % N];
            else                           r[i] = fill;
        end
        return r;
    endfunction

    function automatic logic ref_co(input logic [N-1:0] x, input logic dir, input int a);
        if (a == 0) return 1'b0;
        return dir ? x[a-1] : x[N-a];
    endfunction

    task automatic step(input logic [N-1:0] x, input logic dir, input int a,
                        input logic [1:0] mode, input logic iv, input logic r);
        XX       = x;
        DIR      = dir;
        AMT      = a[M-1:0];
        MODE     = mode;
        in_valid = iv;
        rst      = r;
        @(posedge clk);
        if (r) begin
            m_yy = '0; m_ov = 1'b0; m_co = 1'b0;
        end else if (iv) begin
            m_yy = ref_op(x, dir, a, mode);
            m_ov = 1'b1;
            m_co = ref_co(x, dir, a);
        end else begin
            m_ov = 1'b0;
        end
        #1;
        chk("yy_model", YY, m_yy);
        chk("out_valid_model", out_valid, m_ov);
`ifdef MULTIBIT_CARRY_OUT_EN
        chk("co_model", CO, m_co);
`endif
    endtask

    logic [N-1:0] rr_exp [8] = '{8'b01010110, 8'b00101011, 8'b10010101, 8'b11001010,
                                 8'b01100101, 8'b10110010, 8'b01011001, 8'b10101100};
    logic [N-1:0] w;
    logic [1:0]   modes [4] = '{ROT, LSH, ASH, RSV};

    initial begin
        m_yy = '0; m_ov = 1'b0; m_co = 1'b0;
        XX = '0; DIR = 1'b0; AMT = '0; MODE = ROT; in_valid = 1'b0; rst = 1'b1;
        #2;

        // Reset wins over a simultaneous request
        for (int k = 0; k < 2; k++) begin
            step(8'hFF, 1'b1, 1, ROT, 1'b1, 1'b1);
            chk("reset_yy", YY, 8'h00);
            chk("reset_ov", out_valid, 1'b0);
        end

        w = 8'b10101100;
        for (int k = 0; k < 8; k++) begin
            step(w, 1'b1, 1, ROT, 1'b1, 1'b0);
            chk($sformatf("rotr1_%0d", k), YY, rr_exp[k]);
            w = YY;
        end

        w = 8'b10101100;
        for (int k = 0; k < 8; k++) begin
            step(w, 1'b0, 1, ROT, 1'b1, 1'b0);
            if (k == 0) chk("rotl1_0", YY, 8'b01011001);
            if (k == 1) chk("rotl1_1", YY, 8'b10110010);
            w = YY;
        end
        chk("rotl1_restore", YY, 8'b10101100);

        step(8'b10101100, 1'b1, 3, ROT, 1'b1, 1'b0);
        chk("rotr3", YY, 8'b10010101);
`ifdef MULTIBIT_CARRY_OUT_EN
        chk("rotr3_co", CO, 1'b1);
`endif
        step(8'b10101100, 1'b0, 3, ROT, 1'b1, 1'b0);
        chk("rotl3", YY, 8'b01100101);
`ifdef MULTIBIT_CARRY_OUT_EN
        chk("rotl3_co", CO, 1'b1);
`endif
        step(8'b10101100, 1'b1, 3, LSH, 1'b1, 1'b0);
        chk("lsr3", YY, 8'b00010101);
        step(8'b10101100, 1'b1, 3, ASH, 1'b1, 1'b0);
        chk("asr3", YY, 8'b11110101);
        step(8'b10101100, 1'b0, 3, LSH, 1'b1, 1'b0);
        chk("lsl3", YY, 8'b01100000);
        step(8'b10101100, 1'b0, 3, ASH, 1'b1, 1'b0);
        chk("asl3", YY, 8'b01100000);

        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                step(8'b10101100, d[0], 0, modes[k], 1'b1, 1'b0);
                chk($sformatf("amt0_m%0d_d%0d", k, d), YY, 8'b10101100);
`ifdef MULTIBIT_CARRY_OUT_EN
                chk($sformatf("amt0_co_m%0d_d%0d", k, d), CO, 1'b0);
`endif
            end
        end

        step(8'b00000001, 1'b1, 1, ROT, 1'b1, 1'b0);
        chk("b2b_0", YY, 8'b10000000);
        chk("b2b_0_ov", out_valid, 1'b1);
        step(8'b10000000, 1'b0, 2, ROT, 1'b1, 1'b0);
        chk("b2b_1", YY, 8'b00000010);
        chk("b2b_1_ov", out_valid, 1'b1);
        step(8'hFF, 1'b1, 5, LSH, 1'b0, 1'b0);
        chk("idle_hold", YY, 8'b00000010);
        chk("idle_ov", out_valid, 1'b0);

        // A request followed by reset: the pending result must be dropped
        step(8'h5A, 1'b1, 2, ROT, 1'b1, 1'b0);
        step(8'h3C, 1'b0, 1, ROT, 1'b1, 1'b1);
        chk("midrst_yy", YY, 8'h00);
        chk("midrst_ov", out_valid, 1'b0);

        for (int k = 0; k < 400; k++) begin
            step(N'($urandom), 1'($urandom), int'($urandom_range(0, (1 << M) - 1)),
                 2'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
